// File: rtl/lcd_pkg.sv
// Shared LCD definitions: command/data encodings, frame geometry, the frame
// sequencer state type and the word encoder used by the frame arbiter.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [1:0] LCD_RS_DATA   = 2'b10;
  localparam logic [1:0] LCD_RS_CMD    = 2'b00;

  localparam int unsigned FRAME_WORDS = 34;
  localparam int unsigned LAST_STEP   = FRAME_WORDS - 1;
  localparam int unsigned STEP_W      = 6;
  localparam int unsigned LINE_BITS   = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_ACK,
    ST_WAIT,
    ST_DONE
  } lcd_state_e;

  // One transaction to lcd_controller: {rs, rw, data}.
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_word_t;

  // Word sent at a given frame step; characters go out MSB byte first.
  function automatic lcd_word_t lcd_word(input logic [STEP_W-1:0]    step,
                                         input logic [LINE_BITS-1:0] l1,
                                         input logic [LINE_BITS-1:0] l2);
    logic [3:0] idx;
    lcd_word_t  w;
    idx = '0;
    if (step == '0) begin
      w = {LCD_RS_CMD, LCD_CMD_LINE1};
    end else if (step <= STEP_W'(16)) begin
      idx = 4'(STEP_W'(16) - step);
      w   = {LCD_RS_DATA, l1[{idx, 3'b000} +: 8]};
    end else if (step == STEP_W'(17)) begin
      w = {LCD_RS_CMD, LCD_CMD_LINE2};
    end else begin
      idx = 4'(STEP_W'(LAST_STEP) - step);
      w   = {LCD_RS_DATA, l2[{idx, 3'b000} +: 8]};
    end
    return w;
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin selector: first asserted request at or after ptr, searching
// upward with wrap-around.
//   req   : request vector
//   ptr   : highest-priority index
//   win_c : one-hot winner (zero when no request)
//   any_c : at least one request asserted
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_c,
  output logic             any_c
);

  logic [PTR_W-1:0] k;

  always_comb begin
    win_c = '0;
    any_c = 1'b0;
    k     = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      k = PTR_W'((32'(ptr) + j) % N_REQ);
      if (!any_c && req[k]) begin
        win_c[k] = 1'b1;
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Grants one screen producer per frame (round-robin), snapshots its two
// 16-character lines and plays the 34-word frame into lcd_controller through
// the enable/busy handshake.
//   clk, rst      : clock, synchronous active-high reset
//   req           : per-producer frame request (level)
//   line1, line2  : producer i at bits [128i+127:128i], first char in MSB byte
//   grant         : one-hot, high for the whole frame
//   done          : one-cycle pulse to the producer whose frame completed
//   ack_err       : one-cycle pulse when busy failed to rise in time
//   lcd_enable    : one-cycle strobe per transaction
//   lcd_bus       : {rs, rw, data}, held until the next strobe
//   lcd_busy      : busy flag from lcd_controller
module lcd_frame_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [LINE_BITS*N_REQ-1:0] line1,
  input  logic [LINE_BITS*N_REQ-1:0] line2,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       ack_err,
  output logic                       lcd_enable,
  output logic [9:0]                 lcd_bus,
  input  logic                       lcd_busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  lcd_state_e                      state_q, state_d;
  logic [STEP_W-1:0]               step_q, step_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic [LINE_BITS-1:0]            snap1_q, snap1_d;
  logic [LINE_BITS-1:0]            snap2_q, snap2_d;
  logic [N_REQ-1:0]                grant_d, done_d;
  logic                            ack_err_d, enable_d;
  lcd_word_t                       bus_d;
  logic [N_REQ-1:0]                win_c;
  logic                            any_c;
  logic [N_REQ-1:0][LINE_BITS-1:0] line1_arr, line2_arr;

  assign line1_arr = line1;
  assign line2_arr = line2;

  lcd_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .win_c (win_c),
    .any_c (any_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      ptr_q      <= '0;
      tmo_q      <= '0;
      snap1_q    <= '0;
      snap2_q    <= '0;
      grant      <= '0;
      done       <= '0;
      ack_err    <= 1'b0;
      lcd_enable <= 1'b0;
      lcd_bus    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ptr_q      <= ptr_d;
      tmo_q      <= tmo_d;
      snap1_q    <= snap1_d;
      snap2_q    <= snap2_d;
      grant      <= grant_d;
      done       <= done_d;
      ack_err    <= ack_err_d;
      lcd_enable <= enable_d;
      lcd_bus    <= bus_d;
    end
  end

  // Next state and next register values.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    ptr_d     = ptr_q;
    tmo_d     = tmo_q;
    snap1_d   = snap1_q;
    snap2_d   = snap2_q;
    grant_d   = grant;
    done_d    = '0;
    ack_err_d = 1'b0;
    enable_d  = 1'b0;
    bus_d     = lcd_bus;

    case (state_q)
      ST_IDLE: begin
        if (any_c && !lcd_busy) begin
          grant_d = win_c;
          step_d  = '0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_c[i]) begin
              snap1_d = line1_arr[i];
              snap2_d = line2_arr[i];
            end
          end
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        bus_d    = lcd_word(step_q, snap1_q, snap2_q);
        enable_d = 1'b1;
        tmo_d    = '0;
        state_d  = ST_ACK;
      end

      // Busy rising is the acknowledge; a missing one is reported and skipped.
      ST_ACK: begin
        if (lcd_busy) begin
          state_d = ST_WAIT;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_WAIT: begin
        if (!lcd_busy) begin
          if (step_q == STEP_W'(LAST_STEP)) begin
            done_d  = grant;
            grant_d = '0;
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = ST_SEND;
          end
        end
      end

      // done still holds the winner here; rotate priority past it.
      ST_DONE: begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (done[i]) ptr_d = PTR_W'((i + 1) % N_REQ);
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
module tb_lcd_frame_arbiter;

  localparam int unsigned N_REQ       = 3;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   req = '0;
  logic [383:0] line1 = '0;
  logic [383:0] line2 = '0;
  logic [2:0]   grant;
  logic [2:0]   done;
  logic         ack_err;
  logic         lcd_enable;
  logic [9:0]   lcd_bus;
  logic         lcd_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lcd_frame_arbiter #(.N_REQ(N_REQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .line1      (line1),
    .line2      (line2),
    .grant      (grant),
    .done       (done),
    .ack_err    (ack_err),
    .lcd_enable (lcd_enable),
    .lcd_bus    (lcd_bus),
    .lcd_busy   (lcd_busy)
  );

  // lcd_controller stand-in: busy for busy_len cycles after each strobe (0 = never).
  int busy_len = 4;
  int bcnt = 0;
  always @(posedge clk) begin
    if (lcd_enable && busy_len != 0) bcnt <= busy_len;
    else if (bcnt != 0)              bcnt <= bcnt - 1;
  end
  assign lcd_busy = (bcnt != 0);

  // Scoreboard: {grant index, lcd_bus} per strobe.
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [1:0]  gseq_q[$];
  int          gap_q[$];
  int          ack_lat_q[$];
  int cyc = 0, last_en = 0, last_done = -100;
  int wide_cnt = 0, tear_cnt = 0, ack_cnt = 0, done_total = 0;
  int done_cnt[3] = '{0, 0, 0};
  bit en_prev = 1'b0, g_prev = 1'b0;

  function automatic logic [1:0] gidx(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (lcd_enable) begin
      obs_q.push_back({gidx(grant), lcd_bus});
      if (en_prev) wide_cnt++;
      last_en = cyc;
    end
    en_prev = lcd_enable;
    if (ack_err) begin
      ack_cnt++;
      ack_lat_q.push_back(cyc - last_en);
    end
    if (done != 3'b000) begin
      done_total++;
      last_done = cyc;
      if (grant != 3'b000) tear_cnt++;
    end
    for (int i = 0; i < 3; i++) if (done[i]) done_cnt[i]++;
    if (grant != 3'b000 && !g_prev) begin
      gseq_q.push_back(gidx(grant));
      gap_q.push_back(cyc - last_done);
    end
    g_prev = (grant != 3'b000);
  end

  task automatic set_lines(input int i, input logic [127:0] a, input logic [127:0] b);
    line1[i*128 +: 128] = a;
    line2[i*128 +: 128] = b;
  endtask

  // Expected frame: line-1 command, 16 chars left to right, line-2 command, 16 chars.
  task automatic push_frame(input logic [1:0] idx, input logic [127:0] a, input logic [127:0] b);
    exp_q.push_back({idx, 10'h080});
    for (int c = 0; c < 16; c++) exp_q.push_back({idx, 2'b10, a[127 - 8*c -: 8]});
    exp_q.push_back({idx, 10'h0C0});
    for (int c = 0; c < 16; c++) exp_q.push_back({idx, 2'b10, b[127 - 8*c -: 8]});
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_done(input int target, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_total >= target) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_obs(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (obs_q.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_gseq(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (gseq_q.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant: got %b want 000", grant); end
    vectors++; if (done !== 3'b000) begin miscompares++; $display("FAIL reset_done: got %b want 000", done); end
    vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    vectors++; if (lcd_enable !== 1'b0) begin miscompares++; $display("FAIL reset_enable: got %b want 0", lcd_enable); end
    vectors++; if (lcd_bus !== 10'h000) begin miscompares++; $display("FAIL reset_bus: got %h want 000", lcd_bus); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (grant !== 3'b000 || lcd_enable !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_req: grant %b enable %b want 000 0", grant, lcd_enable);
    end
  endtask

  task automatic test_single_frame();
    logic [127:0] a, b;
    logic [11:0]  e, o;
    int base, d1;
    bit to;
    a = "TEMPERATURA:    ";
    b = "  23.5 C  SENSOR";
    busy_len = 4;
    base = done_total;
    d1 = done_cnt[1];
    set_lines(1, a, b);
    push_frame(2'd1, a, b);
    req = 3'b010;
    @(negedge clk);
    vectors++; if (grant !== 3'b010 || lcd_enable !== 1'b0) begin
      miscompares++; $display("FAIL start_grant: grant %b enable %b want 010 0", grant, lcd_enable);
    end
    @(negedge clk);
    vectors++; if (lcd_enable !== 1'b1 || lcd_bus !== 10'h080) begin
      miscompares++; $display("FAIL start_strobe: enable %b bus %h want 1 080", lcd_enable, lcd_bus);
    end
    req = 3'b000;
    wait_done(base + 1, 3000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL single_done_timeout: got none want done"); end
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt[1] - d1 !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d want 1", done_cnt[1] - d1); end
    vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL single_regrant: got %b want 000", grant); end
    vectors++; if (wide_cnt !== 0) begin miscompares++; $display("FAIL strobe_width: got %0d wide want 0", wide_cnt); end
    vectors++; if (tear_cnt !== 0) begin miscompares++; $display("FAIL grant_at_done: got %0d want 0", tear_cnt); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL single_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL single_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL single_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_round_robin();
    logic [127:0] a[3], b[3];
    logic [1:0]   want[4];
    logic [11:0]  e, o;
    int base;
    bit to;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    busy_len = 1;
    want = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 3; i++) begin a[i] = rnd_line(); b[i] = rnd_line(); set_lines(i, a[i], b[i]); end
    for (int f = 0; f < 4; f++) push_frame(want[f], a[want[f]], b[want[f]]);
    gseq_q.delete();
    base = done_total;
    req = 3'b111;
    wait_gseq(4, 3000, to);
    req = 3'b000;
    vectors++; if (to) begin miscompares++; $display("FAIL rr_grant_timeout: got %0d grants want 4", gseq_q.size()); end
    wait_done(base + 4, 1500, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rr_done_timeout: got %0d want 4", done_total - base); end
    for (int f = 0; f < 4; f++) begin
      vectors++;
      if (gseq_q.size() <= f || gseq_q[f] !== want[f]) begin
        miscompares++; $display("FAIL rr_order[%0d]: got %0d want %0d", f, (gseq_q.size() > f) ? gseq_q[f] : 2'd3, want[f]);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL rr_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL rr_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rr_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    logic [11:0]  e, o;
    int base;
    bit to;
    a = rnd_line(); b = rnd_line();
    set_lines(1, a, b);
    push_frame(2'd1, a, b);
    push_frame(2'd1, a, b);
    busy_len = 1;
    gseq_q.delete(); gap_q.delete();
    base = done_total;
    req = 3'b010;
    wait_gseq(2, 1000, to);
    req = 3'b000;
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout: got %0d grants want 2", gseq_q.size()); end
    wait_done(base + 2, 1000, to);
    vectors++; if (to || gseq_q.size() < 2 || gseq_q[1] !== 2'd1) begin
      miscompares++; $display("FAIL b2b_regrant: got %0d grants want 2 to producer 1", gseq_q.size());
    end
    vectors++; if (gap_q.size() < 2 || gap_q[1] !== 2) begin
      miscompares++; $display("FAIL b2b_gap: got %0d want 2", (gap_q.size() > 1) ? gap_q[1] : -1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL b2b_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL b2b_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_snapshot();
    logic [127:0] a, b;
    logic [11:0]  e, o;
    int base;
    bit to;
    a = rnd_line(); b = rnd_line();
    set_lines(2, a, b);
    push_frame(2'd2, a, b);
    busy_len = 2;
    base = done_total;
    req = 3'b100;
    wait_obs(6, 500, to);
    vectors++; if (to) begin miscompares++; $display("FAIL snap_step5_timeout: got %0d strobes want 6", obs_q.size()); end
    set_lines(2, ~a, ~b);
    req = 3'b000;
    wait_done(base + 1, 1500, to);
    vectors++; if (to) begin miscompares++; $display("FAIL snap_done_timeout: got none want done"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL snap_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL snap_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL snap_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    logic [127:0] a, b;
    logic [11:0]  e, o;
    int base, acks, d0;
    bit to;
    a = rnd_line(); b = rnd_line();
    set_lines(0, a, b);
    push_frame(2'd0, a, b);
    busy_len = 0;
    repeat (8) @(posedge clk);
    gseq_q.delete(); ack_lat_q.delete();
    base = done_total; acks = ack_cnt; d0 = done_cnt[0];
    req = 3'b001;
    wait_gseq(1, 100, to);
    req = 3'b000;
    wait_done(base + 1, 3000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL tmo_done_timeout: got none want done"); end
    vectors++; if (ack_cnt - acks !== 34) begin miscompares++; $display("FAIL tmo_ack_count: got %0d want 34", ack_cnt - acks); end
    vectors++; if (ack_lat_q.size() == 0 || ack_lat_q[0] !== int'(ACK_TIMEOUT)) begin
      miscompares++; $display("FAIL tmo_latency: got %0d want %0d", (ack_lat_q.size() > 0) ? ack_lat_q[0] : -1, ACK_TIMEOUT);
    end
    vectors++; if (done_cnt[0] - d0 !== 1) begin miscompares++; $display("FAIL tmo_done_count: got %0d want 1", done_cnt[0] - d0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL tmo_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL tmo_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL tmo_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
    busy_len = 2;
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] a[3], b[3];
    logic [11:0]  e, o;
    int base, d1;
    bit to;
    for (int i = 0; i < 3; i++) begin a[i] = rnd_line(); b[i] = rnd_line(); set_lines(i, a[i], b[i]); end
    push_frame(2'd1, a[1], b[1]);
    busy_len = 2;
    d1 = done_cnt[1];
    req = 3'b010;
    wait_obs(21, 500, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rmf_step20_timeout: got %0d strobes want 21", obs_q.size()); end
    @(negedge clk);
    rst = 1'b1; req = 3'b000;
    @(negedge clk);
    vectors++; if (lcd_enable !== 1'b0 || grant !== 3'b000 || done !== 3'b000 || lcd_bus !== 10'h000) begin
      miscompares++; $display("FAIL rmf_outputs: enable %b grant %b done %b bus %h want 0 000 000 000", lcd_enable, grant, done, lcd_bus);
    end
    rst = 1'b0;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rmf_partial_word: got %h want %h", o, e); end
    end
    exp_q.delete();
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt[1] !== d1 || grant !== 3'b000) begin
      miscompares++; $display("FAIL rmf_abandon: done %0d grant %b want 0 000", done_cnt[1] - d1, grant);
    end
    // ptr back at 0 means producer 0 wins before producer 2.
    push_frame(2'd0, a[0], b[0]);
    push_frame(2'd2, a[2], b[2]);
    gseq_q.delete();
    base = done_total;
    req = 3'b101;
    wait_gseq(2, 1500, to);
    req = 3'b000;
    wait_done(base + 2, 1500, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rmf_restart_timeout: got %0d frames want 2", done_total - base); end
    vectors++; if (gseq_q.size() < 2 || gseq_q[0] !== 2'd0 || gseq_q[1] !== 2'd2) begin
      miscompares++; $display("FAIL rmf_ptr: got first %0d want 0 then 2", (gseq_q.size() > 0) ? gseq_q[0] : 2'd3);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL rmf_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL rmf_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rmf_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_req_drop();
    logic [127:0] a, b;
    logic [11:0]  e, o;
    int base, d0, ng;
    bit to;
    a = rnd_line(); b = rnd_line();
    set_lines(0, a, b);
    push_frame(2'd0, a, b);
    busy_len = 1;
    base = done_total; d0 = done_cnt[0];
    gseq_q.delete();
    req = 3'b001;
    wait_obs(11, 500, to);
    req = 3'b000;
    vectors++; if (to) begin miscompares++; $display("FAIL drop_step10_timeout: got %0d strobes want 11", obs_q.size()); end
    wait_done(base + 1, 1000, to);
    vectors++; if (to || done_cnt[0] - d0 !== 1) begin miscompares++; $display("FAIL drop_done: got %0d want 1", done_cnt[0] - d0); end
    ng = gseq_q.size();
    repeat (30) @(negedge clk);
    vectors++; if (grant !== 3'b000 || gseq_q.size() !== ng) begin
      miscompares++; $display("FAIL drop_regrant: grant %b want 000", grant);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL drop_word: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL drop_word: got %h want %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL drop_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back();
    test_snapshot();
    test_timeout();
    test_reset_mid_frame();
    test_req_drop();
    vectors++; if (wide_cnt !== 0 || tear_cnt !== 0) begin
      miscompares++; $display("FAIL global_strobe_tear: wide %0d tear %0d want 0 0", wide_cnt, tear_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, want finish before 600000ns");
    $fatal(1, "watchdog");
  end

endmodule
